// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Turns one command (LOADI/MOVE/SWAP/CLRALL/INC/DEC) into the per-cycle
//   enable, function and data pattern for an eight-entry register file
//   (R1-R4 on reg_sel, S1-S4 on scr_sel). Every output is a flop.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   cmd_valid / cmd_ready  command handshake (ready only while idle)
//   cmd_op/dst/src/imm     operation, register indices (0-7), immediate
//   rd_a, rd_b             register-file read data for out_a_sel/out_b_sel
//   i                      register-file write data
//   reg_sel, scr_sel       active-low enables; index 0 -> reg_sel[3] ...
//                          index 7 -> scr_sel[0]
//   fun_sel                000 dec, 001 inc, 010 load i, 011 clear
//   out_a_sel, out_b_sel   register-file read selects
//   busy, done, err        command active / last cycle / reserved opcode
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// READ   | MOVE/SWAP: read selects driven, operands captured at closing edge
// WRITE1 | single write (or first SWAP write, or reserved-op error cycle)
// WRITE2 | SWAP second write (old Dst value into Src)
module regfile_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_dst,
  input  logic [2:0]  cmd_src,
  input  logic [15:0] cmd_imm,
  input  logic [15:0] rd_a,
  input  logic [15:0] rd_b,
  output logic [15:0] i,
  output logic [3:0]  reg_sel,
  output logic [3:0]  scr_sel,
  output logic [2:0]  fun_sel,
  output logic [2:0]  out_a_sel,
  output logic [2:0]  out_b_sel,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] OP_LOADI  = 3'b000;
  localparam logic [2:0] OP_MOVE   = 3'b001;
  localparam logic [2:0] OP_SWAP   = 3'b010;
  localparam logic [2:0] OP_CLRALL = 3'b011;
  localparam logic [2:0] OP_INC    = 3'b100;
  localparam logic [2:0] OP_DEC    = 3'b101;

  localparam logic [2:0] FUN_DEC   = 3'b000;
  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_CLR   = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE1, S_WRITE2} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q, dst_q, src_q, op_nxt, dst_nxt, src_nxt;
  logic [15:0] hold_b, hold_b_nxt;
  logic [15:0] i_nxt;
  logic [7:0]  en_nxt;
  logic [2:0]  fun_nxt, a_sel_nxt, b_sel_nxt;
  logic        ready_nxt, busy_nxt, done_nxt, err_nxt;

  // Active-low enable vector {reg_sel, scr_sel} with only one index low.
  function automatic logic [7:0] en_one(input logic [2:0] idx);
    logic [7:0] e;
    e = 8'hFF;
    e[3'd7 - idx] = 1'b0;
    return e;
  endfunction

  // Outputs are computed for the state being entered, so the flops present
  // them throughout that state. HoldA has no separate flop: the value read
  // in READ goes straight into the i register, which holds it in WRITE1.
  always_comb begin
    state_nxt  = S_IDLE;
    op_nxt     = op_q;
    dst_nxt    = dst_q;
    src_nxt    = src_q;
    hold_b_nxt = hold_b;
    i_nxt      = 16'h0000;
    en_nxt     = 8'hFF;
    fun_nxt    = FUN_LOAD;
    a_sel_nxt  = 3'd0;
    b_sel_nxt  = 3'd0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_nxt    = cmd_op;
          dst_nxt   = cmd_dst;
          src_nxt   = cmd_src;
          busy_nxt  = 1'b1;
          state_nxt = S_WRITE1;
          case (cmd_op)
            OP_LOADI: begin
              en_nxt   = en_one(cmd_dst);
              i_nxt    = cmd_imm;
              done_nxt = 1'b1;
            end
            OP_INC: begin
              en_nxt   = en_one(cmd_dst);
              fun_nxt  = FUN_INC;
              done_nxt = 1'b1;
            end
            OP_DEC: begin
              en_nxt   = en_one(cmd_dst);
              fun_nxt  = FUN_DEC;
              done_nxt = 1'b1;
            end
            OP_CLRALL: begin
              en_nxt   = 8'h00;
              fun_nxt  = FUN_CLR;
              done_nxt = 1'b1;
            end
            OP_MOVE, OP_SWAP: begin
              state_nxt = S_READ;
              a_sel_nxt = cmd_src;
              b_sel_nxt = cmd_dst;
            end
            default: begin
              err_nxt  = 1'b1;
              done_nxt = 1'b1;
            end
          endcase
        end
      end
      S_READ: begin
        hold_b_nxt = rd_b;
        state_nxt  = S_WRITE1;
        busy_nxt   = 1'b1;
        en_nxt     = en_one(dst_q);
        i_nxt      = rd_a;
        done_nxt   = (op_q == OP_MOVE);
      end
      S_WRITE1: begin
        if (op_q == OP_SWAP) begin
          state_nxt = S_WRITE2;
          busy_nxt  = 1'b1;
          en_nxt    = en_one(src_q);
          i_nxt     = hold_b;
          done_nxt  = 1'b1;
        end
      end
      default: ;
    endcase

    ready_nxt = (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= 3'd0;
      dst_q     <= 3'd0;
      src_q     <= 3'd0;
      hold_b    <= 16'h0000;
      cmd_ready <= 1'b1;
      i         <= 16'h0000;
      reg_sel   <= 4'hF;
      scr_sel   <= 4'hF;
      fun_sel   <= FUN_LOAD;
      out_a_sel <= 3'd0;
      out_b_sel <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      dst_q     <= dst_nxt;
      src_q     <= src_nxt;
      hold_b    <= hold_b_nxt;
      cmd_ready <= ready_nxt;
      i         <= i_nxt;
      reg_sel   <= en_nxt[7:4];
      scr_sel   <= en_nxt[3:0];
      fun_sel   <= fun_nxt;
      out_a_sel <= a_sel_nxt;
      out_b_sel <= b_sel_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer
//   Drives regfile_sequencer against a behavioural eight-entry register file
//   and a transaction-level model: each accepted command expands into the
//   list of cycles it must produce, and every cycle the DUT outputs are
//   compared with the head of that list (or the idle pattern when empty).
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [2:0]  cmd_dst = 3'd0;
  logic [2:0]  cmd_src = 3'd0;
  logic [15:0] cmd_imm = 16'h0;
  logic [15:0] rd_a, rd_b, i;
  logic [3:0]  reg_sel, scr_sel;
  logic [2:0]  fun_sel, out_a_sel, out_b_sel;
  logic        busy, done, err;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .rd_a(rd_a), .rd_b(rd_b), .i(i), .reg_sel(reg_sel), .scr_sel(scr_sel),
    .fun_sel(fun_sel), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;
  logic rf_clr = 1'b1;
  logic cmp_en = 1'b0;

  // Register file driven by the DUT's enables.
  logic [15:0] rf [8];
  logic [7:0]  en_dut;
  assign en_dut = {reg_sel, scr_sel};
  assign rd_a = rf[out_a_sel];
  assign rd_b = rf[out_b_sel];

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (rf_clr) rf[k] <= 16'h0;
      else if (en_dut[7-k] == 1'b0) begin
        case (fun_sel)
          3'b010: rf[k] <= i;
          3'b001: rf[k] <= rf[k] + 16'd1;
          3'b000: rf[k] <= rf[k] - 16'd1;
          3'b011: rf[k] <= 16'h0;
          default: ;
        endcase
      end
    end
  end

  // One expected cycle; c* flags say which fields the cycle pins down.
  typedef struct packed {
    logic [7:0]  en;
    logic [2:0]  fun;
    logic        cf;
    logic [15:0] iv;
    logic        ci;
    logic [2:0]  a;
    logic        ca;
    logic [2:0]  b;
    logic        cb;
    logic        dn;
    logic        er;
  } cyc_t;

  cyc_t        q[$];
  logic [15:0] mregs [8];

  function automatic cyc_t mk(logic [7:0] en, logic [2:0] fun, logic cf,
                              logic [15:0] iv, logic ci, logic [2:0] a, logic ca,
                              logic [2:0] b, logic cb, logic dn, logic er);
    cyc_t c;
    c = '{en, fun, cf, iv, ci, a, ca, b, cb, dn, er};
    return c;
  endfunction

  function automatic logic [7:0] one_low(input logic [2:0] idx);
    logic [7:0] e;
    e = 8'hFF;
    e[7 - int'(idx)] = 1'b0;
    return e;
  endfunction

  function automatic void expand(input logic [2:0] op, input logic [2:0] dst,
                                 input logic [2:0] src, input logic [15:0] imm);
    logic [15:0] vs, vd;
    vs = mregs[src];
    vd = mregs[dst];
    case (op)
      3'd0: q.push_back(mk(one_low(dst), 3'b010, 1, imm, 1, 0, 0, 0, 0, 1, 0));
      3'd4: q.push_back(mk(one_low(dst), 3'b001, 1, 16'h0, 1, 0, 0, 0, 0, 1, 0));
      3'd5: q.push_back(mk(one_low(dst), 3'b000, 1, 16'h0, 1, 0, 0, 0, 0, 1, 0));
      3'd3: q.push_back(mk(8'h00, 3'b011, 1, 16'h0, 0, 0, 0, 0, 0, 1, 0));
      3'd1: begin
        q.push_back(mk(8'hFF, 3'b010, 0, 16'h0, 0, src, 1, 0, 0, 0, 0));
        q.push_back(mk(one_low(dst), 3'b010, 1, vs, 1, 0, 0, 0, 0, 1, 0));
      end
      3'd2: begin
        q.push_back(mk(8'hFF, 3'b010, 0, 16'h0, 0, src, 1, dst, 1, 0, 0));
        q.push_back(mk(one_low(dst), 3'b010, 1, vs, 1, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(one_low(src), 3'b010, 1, vd, 1, 0, 0, 0, 0, 1, 0));
      end
      default: q.push_back(mk(8'hFF, 3'b010, 0, 16'h0, 0, 0, 0, 0, 0, 1, 1));
    endcase
  endfunction

  // Model: retire the cycle that just ended (its write lands even when reset
  // is high at this edge), then accept a new command if the model was idle.
  always @(posedge clk) begin
    cyc_t c;
    logic was_idle;
    if (rf_clr) begin
      for (int k = 0; k < 8; k++) mregs[k] = 16'h0;
      q.delete();
    end else begin
      was_idle = (q.size() == 0);
      if (!was_idle) begin
        c = q.pop_front();
        for (int k = 0; k < 8; k++) begin
          if (c.en[7-k] == 1'b0) begin
            case (c.fun)
              3'b010: mregs[k] = c.iv;
              3'b001: mregs[k] = mregs[k] + 16'd1;
              3'b000: mregs[k] = mregs[k] - 16'd1;
              3'b011: mregs[k] = 16'h0;
              default: ;
            endcase
          end
        end
      end
      if (reset) q.delete();
      else if (was_idle && cmd_valid) expand(cmd_op, cmd_dst, cmd_src, cmd_imm);
    end
  end

  always @(negedge clk) begin
    cyc_t e;
    logic eb, ok;
    if (cmp_en) begin
      eb = (q.size() != 0);
      if (eb) e = q[0];
      else e = mk(8'hFF, 3'b010, 1, 16'h0, 1, 0, 1, 0, 1, 0, 0);
      ok = (en_dut === e.en) && (busy === eb) && (cmd_ready === !eb) &&
           (done === e.dn) && (err === e.er) &&
           (!e.cf || fun_sel === e.fun) && (!e.ci || i === e.iv) &&
           (!e.ca || out_a_sel === e.a) && (!e.cb || out_b_sel === e.b);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL cycle t=%0t actual en=%h fun=%0d i=%h a=%0d b=%0d busy=%b done=%b err=%b rdy=%b required en=%h fun=%0d i=%h a=%0d b=%0d busy=%b done=%b err=%b",
                 $time, en_dut, fun_sel, i, out_a_sel, out_b_sel, busy, done, err,
                 cmd_ready, e.en, e.fun, e.iv, e.a, e.b, eb, e.dn, e.er);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first command cycle.
  task automatic send(input logic [2:0] op, input logic [2:0] dst,
                      input logic [2:0] src, input logic [15:0] imm);
    int n;
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready_low required=ready_within_20");
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rf_clr = 1'b0;
    cmp_en = 1'b1;
    reset = 1'b0;
    chk("rst_ready", {15'h0, cmd_ready}, 16'h1);
    chk("rst_en", {8'h0, reg_sel, scr_sel}, 16'h00FF);
    chk("rst_fun", {13'h0, fun_sel}, 16'h2);
    chk("rst_i", i, 16'h0);

    // LOADI into S2
    send(3'd0, 3'd5, 3'd0, 16'hA5A5);
    chk("loadi_scr", {12'h0, scr_sel}, 16'b1011);
    chk("loadi_reg", {12'h0, reg_sel}, 16'hF);
    chk("loadi_i", i, 16'hA5A5);
    chk("loadi_done", {15'h0, done}, 16'h1);
    @(negedge clk);
    chk("loadi_s2", rf[5], 16'hA5A5);

    // MOVE R1 -> S4
    send(3'd0, 3'd0, 3'd0, 16'h1234);
    @(negedge clk);
    send(3'd1, 3'd7, 3'd0, 16'h0);
    chk("move_asel", {13'h0, out_a_sel}, 16'h0);
    chk("move_rd_done", {15'h0, done}, 16'h0);
    @(negedge clk);
    chk("move_scr", {12'h0, scr_sel}, 16'b1110);
    chk("move_i", i, 16'h1234);
    chk("move_done", {15'h0, done}, 16'h1);
    @(negedge clk);
    chk("move_s4", rf[7], 16'h1234);

    // SWAP R2 <-> R3
    send(3'd0, 3'd1, 3'd0, 16'h00FF);
    @(negedge clk);
    send(3'd0, 3'd2, 3'd0, 16'hFF00);
    @(negedge clk);
    send(3'd2, 3'd2, 3'd1, 16'h0);
    chk("swap_c1_done", {15'h0, done}, 16'h0);
    @(negedge clk);
    chk("swap_c2_done", {15'h0, done}, 16'h0);
    chk("swap_c2_reg", {12'h0, reg_sel}, 16'b1101);
    @(negedge clk);
    chk("swap_c3_done", {15'h0, done}, 16'h1);
    chk("swap_c3_reg", {12'h0, reg_sel}, 16'b1011);
    @(negedge clk);
    chk("swap_r2", rf[1], 16'hFF00);
    chk("swap_r3", rf[2], 16'h00FF);

    // CLRALL then DEC R4 back to back
    send(3'd3, 3'd0, 3'd0, 16'h0);
    chk("clr_ready", {15'h0, cmd_ready}, 16'h0);
    chk("clr_en", {8'h0, reg_sel, scr_sel}, 16'h0000);
    send(3'd5, 3'd3, 3'd0, 16'h0);
    chk("dec_reg", {12'h0, reg_sel}, 16'b1110);
    chk("dec_fun", {13'h0, fun_sel}, 16'h0);
    @(negedge clk);
    chk("clr_r1", rf[0], 16'h0);
    chk("clr_s2", rf[5], 16'h0);
    chk("dec_r4", rf[3], 16'hFFFF);

    // Reset during SWAP WRITE1
    send(3'd0, 3'd1, 3'd0, 16'h1111);
    @(negedge clk);
    send(3'd0, 3'd2, 3'd0, 16'h2222);
    @(negedge clk);
    send(3'd2, 3'd2, 3'd1, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_en", {8'h0, reg_sel, scr_sel}, 16'h00FF);
    chk("abort_busy", {15'h0, busy}, 16'h0);
    @(negedge clk);
    chk("abort_ready", {15'h0, cmd_ready}, 16'h1);
    chk("abort_src", rf[1], 16'h1111);
    chk("abort_dst", rf[2], 16'h1111);

    // Reserved opcode held for four cycles
    cmd_op = 3'd6; cmd_dst = 3'd1; cmd_src = 3'd2;
    cmd_valid = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (err === 1'b1 && done === 1'b1 && reg_sel === 4'hF && scr_sel === 4'hF) n++;
    end
    cmd_valid = 1'b0;
    chk("rsvd_err_cycles", 16'(n), 16'd2);

    // Random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 79) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_dst   = 3'($urandom_range(0, 7));
      cmd_src   = 3'($urandom_range(0, 7));
      cmd_imm   = 16'($urandom);
      @(negedge clk);
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 8; k++) chk("final_rf", rf[k], mregs[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
